// File: rtl/muldiv_unit_with_lock.sv
// Shared iterative 32x32 multiply / 32/32 divide unit serving SIC lock/grant requests.
// Oldest-ID arbitration, 32 iterations per op, one-cycle done pulse, rollback abort.
module muldiv_unit_with_lock #(
    parameter int NUM_PORTS = 8,
    parameter int ID_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
    input  logic [NUM_PORTS*2-1:0]        req_op,
    input  logic [NUM_PORTS*32-1:0]       req_a,
    input  logic [NUM_PORTS*32-1:0]       req_b,
    input  logic                          rollback,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [NUM_PORTS-1:0]          done,
    output logic [31:0]                   result_hi,
    output logic [31:0]                   result_lo,
    output logic                          busy
);
    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [4:0]    cnt;
    logic          is_div, neg_q, neg_r;
    logic [31:0]   acc_hi, acc_lo, dreg, res_hi, res_lo;

    // Oldest-ID pick; a strict "older" test keeps the lowest port on equal IDs.
    logic                arb_found;
    logic [OW-1:0]       arb_idx;
    logic [ID_WIDTH-1:0] best_id, cur_id, id_diff;
    logic [1:0]          sel_op;
    logic [31:0]         sel_a, sel_b;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        best_id   = '0;
        cur_id    = '0;
        id_diff   = '0;
        sel_op    = 2'd0;
        sel_a     = 32'd0;
        sel_b     = 32'd0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cur_id  = req_id[p*ID_WIDTH +: ID_WIDTH];
            id_diff = cur_id - best_id;
            if (req_valid[p] && (!arb_found || id_diff[ID_WIDTH-1])) begin
                arb_found = 1'b1;
                arb_idx   = OW'(p);
                best_id   = cur_id;
                sel_op    = req_op[p*2 +: 2];
                sel_a     = req_a[p*32 +: 32];
                sel_b     = req_b[p*32 +: 32];
            end
        end
    end

    logic        sel_signed;
    logic [31:0] a_mag, b_mag;
    assign sel_signed = ~sel_op[0];
    assign a_mag = (sel_signed && sel_a[31]) ? -sel_a : sel_a;
    assign b_mag = (sel_signed && sel_b[31]) ? -sel_b : sel_b;

    // One shift-add or restoring-divide step; sign fixup folded into the last step.
    logic [32:0] add_sum, shifted, sub_diff;
    logic        ge;
    logic [31:0] it_hi, it_lo, nxt_hi, nxt_lo;
    logic [63:0] prod_neg;

    always_comb begin
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dreg} : 33'd0);
        shifted  = {acc_hi, acc_lo[31]};
        sub_diff = shifted - {1'b0, dreg};
        ge       = (shifted >= {1'b0, dreg});
        if (is_div) begin
            it_hi = ge ? sub_diff[31:0] : shifted[31:0];
            it_lo = {acc_lo[30:0], ge};
        end else begin
            it_hi = add_sum[32:1];
            it_lo = {add_sum[0], acc_lo[31:1]};
        end
        nxt_hi   = it_hi;
        nxt_lo   = it_lo;
        prod_neg = -{it_hi, it_lo};
        if (cnt == 5'd31) begin
            if (!is_div && neg_q) {nxt_hi, nxt_lo} = prod_neg;
            if (is_div && neg_q)  nxt_lo = -it_lo;
            if (is_div && neg_r)  nxt_hi = -it_hi;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            dreg   <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            case (state)
                IDLE: if (arb_found && !rollback) begin
                    state  <= BUSY;
                    owner  <= arb_idx;
                    cnt    <= 5'd0;
                    is_div <= sel_op[1];
                    // Divide-by-zero keeps the all-ones quotient unsigned.
                    neg_q  <= sel_signed & (sel_a[31] ^ sel_b[31]) & ~(sel_op[1] & (sel_b == 32'd0));
                    neg_r  <= sel_signed & sel_op[1] & sel_a[31];
                    acc_hi <= 32'd0;
                    acc_lo <= sel_op[1] ? a_mag : b_mag;
                    dreg   <= sel_op[1] ? b_mag : a_mag;
                end
                BUSY: begin
                    if (rollback || !req_valid[owner]) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= nxt_hi;
                        acc_lo <= nxt_lo;
                        cnt    <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!rollback) begin
                        res_hi <= acc_hi;
                        res_lo <= acc_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are shown live during DONE and committed only if it was not rolled back.
    logic in_done;
    assign in_done = (state == DONE) && !rollback;

    always_comb begin
        grant = '0;
        if (state != IDLE) grant[owner] = 1'b1;
    end

    assign done      = in_done ? grant : '0;
    assign result_hi = in_done ? acc_hi : res_hi;
    assign result_lo = in_done ? acc_lo : res_lo;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Directed bench for muldiv_unit_with_lock: vector table plus arbitration/abort/reset sequences.
module tb_muldiv_unit_with_lock;
    localparam int NP = 8;
    localparam int IW = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NP-1:0]           req_valid;
    logic [NP-1:0][IW-1:0]   req_id;
    logic [NP-1:0][1:0]      req_op;
    logic [NP-1:0][31:0]     req_a, req_b;
    logic                    rollback;
    logic [NP-1:0]           grant, done;
    logic [31:0]             result_hi, result_lo;
    logic                    busy;

    muldiv_unit_with_lock #(.NUM_PORTS(NP), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_id(req_id), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rollback(rollback), .grant(grant), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [15:0] id;
        logic [31:0] hi, lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int port, output int cyc);
        bit seen = 1'b0;
        port = -1;
        cyc  = 0;
        for (int i = 1; i <= 80 && !seen; i++) begin
            @(negedge clk);
            if (|done) begin
                seen = 1'b1;
                cyc  = i;
                for (int p = 0; p < NP; p++) if (done[p]) port = p;
            end
        end
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] id);
        req_valid[p] = 1'b1;
        req_op[p]    = op;
        req_a[p]     = a;
        req_b[p]     = b;
        req_id[p]    = id;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int p, c;
        set_req(v.port, v.op, v.a, v.b, v.id);
        @(negedge clk);
        chk({tag, " grant"}, 64'(grant), 64'(1 << v.port));
        wait_done(p, c);
        chk({tag, " done_port"}, 64'(p), 64'(v.port));
        chk({tag, " latency"}, 64'(c + 1), 64'd33);
        chk({tag, " hi_lo"}, {result_hi, result_lo}, {v.hi, v.lo});
        req_valid[v.port] = 1'b0;
        @(negedge clk);
        chk({tag, " idle_after"}, {55'd0, busy, grant}, 64'd0);
        chk({tag, " held"}, {result_hi, result_lo}, {v.hi, v.lo});
    endtask

    int   p, c;
    int   exp_order[3] = '{2, 5, 0};
    logic [31:0] exp_lo[3] = '{32'd12, 32'd25, 32'd100};
    vec_t v9;

    initial begin
        req_valid = '0; req_id = '0; req_op = '0; req_a = '0; req_b = '0; rollback = 1'b0;

        //               port op    a             b             id       hi            lo
        vecs[0] = '{0, 2'd1, 32'd7,        32'd6,        16'd1, 32'd0,        32'd42};
        vecs[1] = '{3, 2'd0, 32'hFFFFFFFF, 32'd2,        16'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2] = '{3, 2'd2, 32'hFFFFFFF9, 32'd2,        16'd3, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{1, 2'd3, 32'd100,      32'd0,        16'd4, 32'h00000064, 32'hFFFFFFFF};
        vecs[4] = '{1, 2'd2, 32'h80000000, 32'hFFFFFFFF, 16'd5, 32'd0,        32'h80000000};
        vecs[5] = '{2, 2'd0, 32'h80000000, 32'h80000000, 16'd6, 32'h40000000, 32'd0};
        vecs[6] = '{4, 2'd3, 32'hFFFFFFFF, 32'd16,       16'd7, 32'd15,       32'h0FFFFFFF};
        vecs[7] = '{5, 2'd2, 32'd7,        32'hFFFFFFFE, 16'd8, 32'd1,        32'hFFFFFFFD};
        vecs[8] = '{6, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd9, 32'hFFFFFFFE, 32'h00000001};
        vecs[9] = '{7, 2'd2, 32'hFFFFFFFB, 32'd0,        16'd10, 32'hFFFFFFFB, 32'hFFFFFFFF};
        v9      = '{0, 2'd1, 32'd3,        32'd3,        16'd50, 32'd0,       32'd9};

        #2;
        chk("reset outs", {result_hi, result_lo}, 64'd0);
        chk("reset ctl", {47'd0, busy, grant, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Three same-cycle requesters: oldest ID first, ties to the lower port.
        set_req(0, 2'd1, 32'd10, 32'd10, 16'd9);
        set_req(2, 2'd1, 32'd3,  32'd4,  16'd5);
        set_req(5, 2'd1, 32'd5,  32'd5,  16'd5);
        @(negedge clk);
        chk("arb first grant", 64'(grant), 64'(1 << 2));
        for (int k = 0; k < 3; k++) begin
            wait_done(p, c);
            chk($sformatf("arb order%0d", k), 64'(p), 64'(exp_order[k]));
            chk($sformatf("arb lo%0d", k), 64'(result_lo), 64'(exp_lo[k]));
            chk($sformatf("arb spacing%0d", k), 64'(c), (k == 0) ? 64'd32 : 64'd34);
            if (p >= 0) req_valid[p] = 1'b0;
        end
        @(negedge clk);

        // ID wrap: 0xFFFE is older than 0x0001; dropping the owner aborts.
        set_req(1, 2'd1, 32'd1, 32'd1, 16'h0001);
        set_req(6, 2'd1, 32'd1, 32'd1, 16'hFFFE);
        @(negedge clk);
        chk("wrap grant", 64'(grant), 64'(1 << 6));
        req_valid = '0;
        @(negedge clk);
        chk("wrap abort idle", {63'd0, busy}, 64'd0);

        // Rollback at BUSY cycle 10 with port 4 waiting.
        set_req(0, 2'd1, 32'd11, 32'd11, 16'd1);
        set_req(4, 2'd3, 32'd50, 32'd7,  16'd2);
        @(negedge clk);
        chk("rb grant", 64'(grant), 64'(1 << 0));
        c = 0;
        repeat (9) begin
            @(negedge clk);
            if (|done) c++;
        end
        rollback = 1'b1;
        @(negedge clk);
        chk("rb no done", 64'(c) | 64'(done), 64'd0);
        chk("rb idle", {63'd0, busy}, 64'd0);
        chk("rb results held", {result_hi, result_lo}, {32'd0, 32'd100});
        rollback = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rb waiter grant", 64'(grant), 64'(1 << 4));
        wait_done(p, c);
        chk("rb waiter port", 64'(p), 64'd4);
        chk("rb waiter result", {result_hi, result_lo}, {32'd1, 32'd7});
        req_valid[4] = 1'b0;
        @(negedge clk);

        // Owner drops req_valid at BUSY cycle 20 with port 7 waiting.
        set_req(3, 2'd1, 32'd5, 32'd5, 16'd10);
        set_req(7, 2'd1, 32'd2, 32'd3, 16'd20);
        @(negedge clk);
        chk("drop grant", 64'(grant), 64'(1 << 3));
        c = 0;
        repeat (19) begin
            @(negedge clk);
            if (|done) c++;
        end
        req_valid[3] = 1'b0;
        @(negedge clk);
        chk("drop no done", 64'(c) | 64'(done), 64'd0);
        chk("drop idle", {63'd0, busy}, 64'd0);
        chk("drop results held", {result_hi, result_lo}, {32'd1, 32'd7});
        @(negedge clk);
        chk("drop waiter grant", 64'(grant), 64'(1 << 7));
        wait_done(p, c);
        chk("drop waiter port", 64'(p), 64'd7);
        chk("drop waiter lo", 64'(result_lo), 64'd6);
        req_valid[7] = 1'b0;
        @(negedge clk);

        // Rollback together with a request in IDLE blocks acceptance.
        rollback = 1'b1;
        set_req(2, 2'd1, 32'd4, 32'd4, 16'd0);
        @(negedge clk);
        chk("idle rb blocks", {63'd0, busy}, 64'd0);
        rollback = 1'b0;
        @(negedge clk);
        chk("idle rb later grant", 64'(grant), 64'(1 << 2));
        wait_done(p, c);
        chk("idle rb lo", 64'(result_lo), 64'd16);
        req_valid[2] = 1'b0;
        @(negedge clk);

        // Rollback during DONE: no pulse, no commit.
        set_req(1, 2'd1, 32'd9, 32'd9, 16'd0);
        @(negedge clk);
        repeat (32) @(negedge clk);
        rollback = 1'b1;
        #1;
        chk("done rb busy", {63'd0, busy}, 64'd1);
        chk("done rb suppressed", 64'(done), 64'd0);
        chk("done rb shown", 64'(result_lo), 64'd16);
        @(negedge clk);
        chk("done rb idle", {63'd0, busy}, 64'd0);
        chk("done rb no commit", 64'(result_lo), 64'd16);
        rollback = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-BUSY.
        set_req(0, 2'd1, 32'd1000, 32'd1000, 16'd0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst results", {result_hi, result_lo}, 64'd0);
        chk("async rst ctl", {47'd0, busy, grant, done}, 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec("post_rst", v9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit_with_lock.md
Name: muldiv_unit_with_lock

Overview:
- Shared iterative multiply/divide responder for the SIC array. It is the serving end of the per-SIC lock/grant request protocol that SICs already use toward the ALU pool and data memory.
- Each SIC raises a request tagged with its issue ID. The unit grants the oldest requester, computes a 64-bit HI/LO result over 32 iterations, and returns it with a one-cycle done pulse.
- A rollback input aborts in-flight work.

Parameters:
- NUM_PORTS, 8, number of SIC request ports.
- ID_WIDTH, 16, issue-ID width; IDs wrap modulo 2^ID_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_PORTS  per-port request. Held high with stable operands until done, or dropped to abort.
- req_id  input  NUM_PORTS*ID_WIDTH  per-port issue ID; port p occupies bits [p*ID_WIDTH +: ID_WIDTH].
- req_op  input  NUM_PORTS*2  per-port opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- req_a  input  NUM_PORTS*32  per-port operand A (multiplicand or dividend).
- req_b  input  NUM_PORTS*32  per-port operand B (multiplier or divisor).
- rollback  input  1  pipeline flush; cancels any owned operation.
- grant  output  NUM_PORTS  one-hot owner indication; all zero when idle.
- done  output  NUM_PORTS  one-hot, one-cycle result-valid pulse to the owner.
- result_hi  output  32  HI result (product high word or remainder); broadcast to all ports.
- result_lo  output  32  LO result (product low word or quotient); broadcast to all ports.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; grant=0, done=0, result_hi=0, result_lo=0, busy=0; owner, counter and datapath registers cleared. Reset mid-operation discards all work and emits no done.
- States: IDLE, BUSY, DONE.
- IDLE, arbitration:
  - Among ports with req_valid=1, pick the oldest ID. ID a is older than b iff bit ID_WIDTH-1 of (a-b) mod 2^ID_WIDTH is 1.
  - Equal IDs: lowest port index wins.
  - On the edge with any valid request and rollback=0: latch owner, op and operands; counter=0; go to BUSY. grant[owner]=1 from the next cycle.
- BUSY:
  - One iteration per cycle, counter 0..31; after iteration 31, go to DONE.
  - MULT/MULTU: radix-2 shift-add on a 64-bit accumulator.
  - Signed MULT and DIV use magnitudes internally, with sign fixup applied on entry to DONE.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
- DONE (exactly one cycle):
  - done[owner]=1; result_hi/result_lo valid. They hold their values until the next DONE or reset.
  - Next state IDLE; grant drops with it.
- Latency: done is asserted in the 33rd cycle after the accepting edge. Throughput is one operation per 34 cycles; a new request can only be accepted in IDLE.
- Signed semantics:
  - Product is 64-bit two's complement.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0.
- Divide by zero (DIV and DIVU): lo=0xFFFFFFFF, hi=dividend. Still takes the full latency.
- Abort: rollback=1 in BUSY or DONE, or req_valid[owner]=0 in BUSY, forces IDLE next edge.
  - done is suppressed in that cycle if rollback is high during DONE.
  - No result registers update.
  - rollback=1 in IDLE blocks acceptance for that cycle.
- Requests from non-owners are ignored (grant=0) while busy. Requesters keep req_valid high and compete again at the next IDLE cycle.
- Operand changes by the owner after acceptance have no effect; operands are latched.
- Simultaneous rollback and new request in IDLE: no acceptance.

Test Plan:
- Port 0 MULTU a=7, b=6 -> grant[0]=1 next cycle; done[0] 33 cycles after acceptance; hi=0, lo=42; busy then drops.
- Port 3 MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Port 1 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64 after the full 33-cycle latency. Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Same-cycle requests: port 0 id=9, port 2 id=5, port 5 id=5 -> port 2 served first, then port 5, then port 0. Wrap case: id 0xFFFE beats id 0x0001.
- rollback pulse at BUSY cycle 10, and separately owner req_valid dropped at cycle 20 -> no done pulse; IDLE next cycle; result_hi/result_lo keep their previous values; a waiting port is accepted on the following edge.
- rst asserted asynchronously mid-BUSY -> all outputs 0 immediately; after release, a fresh MULTU 3*3 returns lo=9.
